// File: rtl/ips_spike_gen.sv
// rtl/ips_spike_gen.sv - Bernoulli input-pattern spike generator driven by start/next handshake
//
// Holds one 8-bit intensity per input pixel and emits one M-bit spike vector
// per cycle while next_ips_gen is high. A shared 32-bit LFSR supplies the
// random value; each pixel takes its own 8-bit window of it, salted with the
// pixel index.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pix_we          pixel intensity write strobe (accepted only in IDLE)
//   pix_addr        pixel index for the write
//   pix_data        pixel intensity (0 never spikes, 255 always spikes)
//   start_ips_gen   one-cycle pulse: start a presentation, reseed the LFSR
//   next_ips_gen    level: one spike vector per cycle while high in RUN
//   ips_gen_out     registered spike vector, bit i = pixel i
//   ips_valid       ips_gen_out was generated on the last edge
//   step_count      vectors generated since the last start, saturating at 255
//   wr_err          one-cycle pulse: the last write was rejected
module ips_spike_gen #(
  parameter int          M    = 784,
  parameter int          AW   = 10,
  parameter logic [31:0] SEED = 32'hACE12468
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_we,
  input  logic [AW-1:0] pix_addr,
  input  logic [7:0]    pix_data,
  input  logic          start_ips_gen,
  input  logic          next_ips_gen,
  output logic [M-1:0]  ips_gen_out,
  output logic          ips_valid,
  output logic [7:0]    step_count,
  output logic          wr_err
);

  typedef enum logic {IDLE, RUN} state_t;

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  // One extra bit so M == 2**AW still compares correctly.
  localparam logic [AW:0] M_LIM = (AW + 1)'(M);

  state_t      state;
  logic [31:0] lfsr;
  logic        low_seen;   // one idle (next low) cycle already seen after a step
  logic [7:0]  intensity [M];
  logic [M-1:0] spike;
  logic        addr_ok;

  assign addr_ok = ({1'b0, pix_addr} < M_LIM);

  // Intensity storage: never reset, so a loaded image survives rst.
  always_ff @(posedge clk) begin
    if (pix_we && (state == IDLE) && addr_ok) begin
      intensity[pix_addr] <= pix_data;
    end
  end

  // Per-pixel compare against a window of the current LFSR value. Windows
  // repeat every 25 pixels; XOR with the pixel index decorrelates them.
  always_comb begin
    logic [7:0] rnd;
    spike = '0;
    rnd   = '0;
    for (int i = 0; i < M; i++) begin
      rnd      = lfsr[(i % 25) +: 8] ^ 8'(i);
      spike[i] = (intensity[i] != 8'd0) && (intensity[i] >= rnd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED_EFF;
      ips_gen_out <= '0;
      ips_valid   <= 1'b0;
      step_count  <= 8'd0;
      wr_err      <= 1'b0;
      low_seen    <= 1'b0;
    end else begin
      wr_err <= pix_we && ((state == RUN) || !addr_ok);

      if (start_ips_gen) begin
        // Start wins over a simultaneous next; no vector this cycle.
        state       <= RUN;
        lfsr        <= SEED_EFF;
        step_count  <= 8'd0;
        ips_gen_out <= '0;
        ips_valid   <= 1'b0;
        low_seen    <= 1'b0;
      end else if ((state == RUN) && next_ips_gen) begin
        ips_gen_out <= spike;
        ips_valid   <= 1'b1;
        if (step_count != 8'hFF) begin
          step_count <= step_count + 8'd1;
        end
        lfsr     <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        low_seen <= 1'b0;
      end else begin
        ips_valid <= 1'b0;
        // Two consecutive idle cycles after at least one step end the run.
        if ((state == RUN) && (step_count != 8'd0)) begin
          if (low_seen) begin
            state    <= IDLE;
            low_seen <= 1'b0;
          end else begin
            low_seen <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ips_spike_gen.sv
// tb/tb_ips_spike_gen.sv - self-checking bench for ips_spike_gen against a reference model
module tb_ips_spike_gen;

  localparam int          M    = 784;
  localparam int          AW   = 10;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_data;
  logic          start_ips_gen;
  logic          next_ips_gen;
  logic [M-1:0]  ips_gen_out;
  logic          ips_valid;
  logic [7:0]    step_count;
  logic          wr_err;

  ips_spike_gen #(.M(M), .AW(AW), .SEED(SEED)) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_we        (pix_we),
    .pix_addr      (pix_addr),
    .pix_data      (pix_data),
    .start_ips_gen (start_ips_gen),
    .next_ips_gen  (next_ips_gen),
    .ips_gen_out   (ips_gen_out),
    .ips_valid     (ips_valid),
    .step_count    (step_count),
    .wr_err        (wr_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]   m_int [M];
  bit           m_run;
  logic [31:0]  m_lfsr;
  int           m_steps;
  int           m_low;
  logic [M-1:0] m_out;
  logic         m_valid;
  logic         m_werr;

  logic [M-1:0] first_run [$];
  logic [M-1:0] all_ones_but5;

  function automatic logic [M-1:0] model_vec(input logic [31:0] l);
    logic [M-1:0] v;
    logic [7:0]   r;
    v = '0;
    for (int i = 0; i < M; i++) begin
      r    = 8'((l >> (i % 25)) & 32'hFF) ^ 8'(i % 256);
      v[i] = (m_int[i] != 8'd0) && (m_int[i] >= r);
    end
    return v;
  endfunction

  function automatic logic [31:0] model_lfsr_next(input logic [31:0] l);
    // feedback is the parity of taps 31, 21, 1, 0
    return (l << 1) | 32'(^(l & 32'h8020_0003));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs now applied, clock the
  // DUT, then compare every output.
  task automatic cycle();
    if (rst) begin
      m_run = 0; m_lfsr = SEED; m_steps = 0; m_low = 0;
      m_out = '0; m_valid = 0; m_werr = 0;
    end else begin
      m_werr = pix_we && (m_run || int'(pix_addr) >= M);
      if (pix_we && !m_run && int'(pix_addr) < M) m_int[pix_addr] = pix_data;
      if (start_ips_gen) begin
        m_run = 1; m_lfsr = SEED; m_steps = 0; m_low = 0;
        m_out = '0; m_valid = 0;
      end else if (m_run && next_ips_gen) begin
        m_out   = model_vec(m_lfsr);
        m_valid = 1;
        m_steps = (m_steps < 255) ? m_steps + 1 : 255;
        m_lfsr  = model_lfsr_next(m_lfsr);
        m_low   = 0;
      end else begin
        m_valid = 0;
        if (m_run && m_steps > 0) begin
          m_low++;
          if (m_low == 2) begin
            m_run = 0;
            m_low = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk_vec("ips_gen_out", ips_gen_out, m_out);
    chk("ips_valid", 32'(ips_valid), 32'(m_valid));
    chk("step_count", 32'(step_count), 32'(m_steps));
    chk("wr_err", 32'(wr_err), 32'(m_werr));
  endtask

  task automatic write_pix(input int addr, input logic [7:0] data);
    pix_we = 1; pix_addr = AW'(addr); pix_data = data;
    cycle();
    pix_we = 0;
  endtask

  task automatic run_steps(input int n);
    next_ips_gen = 1;
    repeat (n) cycle();
  endtask

  task automatic go_idle();
    next_ips_gen = 0;
    repeat (3) cycle();
  endtask

  task automatic start_pulse(input logic with_next);
    start_ips_gen = 1; next_ips_gen = with_next;
    cycle();
    start_ips_gen = 0;
  endtask

  initial begin
    rst = 1; pix_we = 0; pix_addr = '0; pix_data = '0;
    start_ips_gen = 0; next_ips_gen = 0;
    for (int i = 0; i < M; i++) m_int[i] = 'x;

    // Reset, then next without start must do nothing
    repeat (2) cycle();
    rst = 0;
    chk_vec("reset_out", ips_gen_out, '0);
    chk("reset_steps", 32'(step_count), 32'd0);
    run_steps(5);
    chk("idle_next_valid", 32'(ips_valid), 32'd0);
    next_ips_gen = 0;

    // Extremes: all 255 except pixel 5 = 0
    for (int i = 0; i < M; i++) write_pix(i, (i == 5) ? 8'd0 : 8'd255);
    start_pulse(1'b0);
    all_ones_but5 = '1;
    all_ones_but5[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      next_ips_gen = 1;
      cycle();
      chk_vec("extreme_vec", ips_gen_out, all_ones_but5);
      chk("extreme_valid", 32'(ips_valid), 32'd1);
    end
    chk("extreme_steps", 32'(step_count), 32'd10);
    go_idle();

    // Golden model with random intensities, 201 steps
    for (int i = 0; i < M; i++) write_pix(i, 8'($urandom_range(0, 255)));
    start_pulse(1'b0);
    next_ips_gen = 1;
    for (int k = 0; k < 201; k++) begin
      cycle();
      if (k < 50) first_run.push_back(m_out);
    end
    chk("golden_steps", 32'(step_count), 32'd201);

    // Restart together with next: no vector, then identical sequence
    start_pulse(1'b1);
    chk("restart_valid", 32'(ips_valid), 32'd0);
    chk("restart_steps", 32'(step_count), 32'd0);
    next_ips_gen = 1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      chk_vec("restart_vec", ips_gen_out, first_run[k]);
    end

    // Write rejection in RUN
    pix_we = 1; pix_addr = AW'(3); pix_data = 8'h80;
    cycle();
    pix_we = 0;
    chk("run_wr_err", 32'(wr_err), 32'd1);
    cycle();
    chk("run_wr_err_once", 32'(wr_err), 32'd0);
    go_idle();
    write_pix(800, 8'h55);
    chk("oob_wr_err", 32'(wr_err), 32'd1);
    write_pix(3, 8'h80);
    chk("idle_wr_ok", 32'(wr_err), 32'd0);
    start_pulse(1'b0);
    run_steps(20);
    go_idle();

    // Saturation, then reset mid-run
    for (int i = 0; i < M; i++)
      if ($urandom_range(0, 3) == 0) write_pix(i, 8'($urandom_range(0, 255)));
    start_pulse(1'b0);
    run_steps(300);
    chk("sat_steps", 32'(step_count), 32'd255);
    rst = 1;
    cycle();
    chk_vec("midrst_out", ips_gen_out, '0);
    chk("midrst_valid", 32'(ips_valid), 32'd0);
    chk("midrst_steps", 32'(step_count), 32'd0);
    rst = 0;
    run_steps(3);
    chk("midrst_idle", 32'(ips_valid), 32'd0);
    next_ips_gen = 0;
    start_pulse(1'b0);
    run_steps(20);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
